aes_inv_sbox_arbiter: RTL and testbench

AES_INV_SBOX_ARBITER -- requirements
Module: aes_inv_sbox_arbiter

---
 rtl/aes_inv_sbox_arbiter.sv | 121 ++++++++++++
 tb/tb_aes_inv_sbox_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/aes_inv_sbox_arbiter.sv
// Round-robin arbiter sharing one combinational 128-bit inverse S-box
// among NREQ requesters, with a one-cycle registered response path.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   req            per-requester request level (held until granted)
//   req_lock       per-requester lock; a locked winner keeps priority
//   req_data       NREQ packed 128-bit blocks, requester i at [128*i +: 128]
//   gnt            one-hot combinational grant
//   sbox_in        winner's block to the shared S-box (zero when idle)
//   sbox_out       S-box result, sampled on the grant edge
//   rsp_valid      one-hot registered response strobe
//   rsp_data       registered substituted block
//   busy           registered, high while a response is presented

// Per-requester slice: passes its block through only when granted, so the
// S-box input is a plain OR of all lanes.
module aes_inv_sbox_arb_lane (
  input  logic         gnt,
  input  logic [127:0] data,
  output logic [127:0] masked
);
  assign masked = gnt ? data : 128'h0;
endmodule

module aes_inv_sbox_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*128-1:0]    req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [127:0]           sbox_in,
  input  logic [127:0]           sbox_out,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [127:0]           rsp_data,
  output logic                   busy
);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [127:0]            rsp_data_q, rsp_data_d;
  logic                    busy_q, busy_d;

  logic                    found;
  logic [PTR_W-1:0]        win;
  logic [PTR_W:0]          idx;
  logic [NREQ-1:0][127:0]  lane_data;

  // Search from ptr upward, wrapping at NREQ; first requester seen wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NREQ)) idx = idx - (PTR_W+1)'(NREQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  // Reset gates the grant combinationally so nothing reaches the S-box
  // while reset_n is low.
  always_comb begin
    gnt = '0;
    if (found && reset_n) gnt[win] = 1'b1;
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    aes_inv_sbox_arb_lane u_lane (
      .gnt    (gnt[g]),
      .data   (req_data[128*g +: 128]),
      .masked (lane_data[g])
    );
  end

  always_comb begin
    sbox_in = 128'h0;
    for (int j = 0; j < NREQ; j++) sbox_in = sbox_in | lane_data[j];
  end

  // Next state: response tracks this cycle's grant; data holds when idle.
  // A locked winner keeps the pointer, otherwise it moves past the winner.
  always_comb begin
    rsp_valid_d = gnt;
    busy_d      = |gnt;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    if (|gnt) begin
      rsp_data_d = sbox_out;
      if (req_lock[win])                    ptr_d = win;
      else if (win == PTR_W'(NREQ-1))       ptr_d = '0;
      else                                  ptr_d = win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 128'h0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_sbox_arbiter.sv
module tb_aes_inv_sbox_arbiter;

  localparam logic [127:0] D0 = {16{8'h7c}};  // InvS(7c)=01
  localparam logic [127:0] D1 = {16{8'h00}};  // InvS(00)=52
  localparam logic [127:0] D2 = {16{8'h63}};  // InvS(63)=00
  localparam logic [127:0] D3 = {16{8'h77}};  // InvS(77)=02
  localparam logic [127:0] R0 = {16{8'h01}};
  localparam logic [127:0] R1 = {16{8'h52}};
  localparam logic [127:0] R2 = 128'h0;
  localparam logic [127:0] R3 = {16{8'h02}};
  localparam logic [127:0] Z  = 128'h0;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req, req_lock;
  logic [511:0]  req_data;
  logic [3:0]    gnt, rsp_valid;
  logic [127:0]  sbox_in, sbox_out, rsp_data;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  aes_inv_sbox_arbiter #(.NREQ(4), .PTR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_lock(req_lock),
    .req_data(req_data), .gnt(gnt), .sbox_in(sbox_in), .sbox_out(sbox_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partial inverse S-box: first row of InvS plus the inverses of the first
  // row of the forward S-box; stimulus only uses these byte values.
  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    case (b)
      8'h00: return 8'h52; 8'h01: return 8'h09; 8'h02: return 8'h6a;
      8'h03: return 8'hd5; 8'h63: return 8'h00; 8'h7c: return 8'h01;
      8'h77: return 8'h02; 8'h7b: return 8'h03; 8'h52: return 8'h48;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    sbox_out = 128'h0;
    for (int k = 0; k < 16; k++) sbox_out[8*k +: 8] = inv_byte(sbox_in[8*k +: 8]);
  end

  function automatic logic [127:0] exp_sbox(input logic [3:0] g);
    case (g)
      4'b0001: return D0;
      4'b0010: return D1;
      4'b0100: return D2;
      4'b1000: return D3;
      default: return Z;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Registered expectations (rv/rd/busy) reflect the previous row's grant.
  typedef struct {
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [3:0]   gnt;
    logic [3:0]   rv;
    logic [127:0] rd;
    logic         busy;
  } vec_t;

  vec_t tbl[23];

  initial begin
    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, Z,  1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, Z,  1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0100, R2, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b1000, R3, 1'b1};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0001, R0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b0010, R1, 1'b1};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0100, R2, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b1000, R3, 1'b1};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, R0, 1'b1};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, R0, 1'b0};
    tbl[10] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, R0, 1'b0};
    tbl[11] = '{1'b1, 4'b0011, 4'b0001, 4'b0001, 4'b1000, R3, 1'b1};
    tbl[12] = '{1'b1, 4'b0011, 4'b0001, 4'b0001, 4'b0001, R0, 1'b1};
    tbl[13] = '{1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, R0, 1'b1};
    tbl[14] = '{1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0001, R0, 1'b1};
    tbl[15] = '{1'b1, 4'b0011, 4'b0010, 4'b0001, 4'b0010, R1, 1'b1};
    tbl[16] = '{1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0001, R0, 1'b1};
    tbl[17] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0010, R1, 1'b1};
    tbl[18] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 4'b0100, R2, 1'b1};
    tbl[19] = '{1'b1, 4'b1001, 4'b0000, 4'b0001, 4'b1000, R3, 1'b1};
    tbl[20] = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0001, R0, 1'b1};
    tbl[21] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, R1, 1'b1};
    tbl[22] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, R1, 1'b0};

    reset_n  = 1'b0;
    req      = 4'b0;
    req_lock = 4'b0;
    req_data = {D3, D2, D1, D0};

    for (int r = 0; r < 23; r++) begin
      @(negedge clk);
      reset_n  = tbl[r].rst_n;
      req      = tbl[r].req;
      req_lock = tbl[r].lock;
      #1;
      chk($sformatf("row%0d gnt", r),       128'(gnt),       128'(tbl[r].gnt));
      chk($sformatf("row%0d sbox_in", r),   sbox_in,         exp_sbox(tbl[r].gnt));
      chk($sformatf("row%0d rsp_valid", r), 128'(rsp_valid), 128'(tbl[r].rv));
      chk($sformatf("row%0d rsp_data", r),  rsp_data,        tbl[r].rd);
      chk($sformatf("row%0d busy", r),      128'(busy),      128'(tbl[r].busy));
    end

    // Reset asserted after a grant to requester 1 but before its edge.
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk("mid gnt",     128'(gnt), 128'(4'b0010));
    chk("mid sbox_in", sbox_in,   D1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst gnt",       128'(gnt),       128'(4'b0000));
    chk("rst sbox_in",   sbox_in,         Z);
    chk("rst rsp_valid", 128'(rsp_valid), 128'(4'b0000));
    chk("rst rsp_data",  rsp_data,        Z);
    chk("rst busy",      128'(busy),      128'(1'b0));

    @(negedge clk);
    reset_n = 1'b1;
    req     = 4'b0000;
    @(posedge clk); #1;
    chk("post rsp_valid", 128'(rsp_valid), 128'(4'b0000));
    chk("post rsp_data",  rsp_data,        Z);
    chk("post busy",      128'(busy),      128'(1'b0));

    // Pointer restarts at 0 after reset.
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk("resume gnt", 128'(gnt), 128'(4'b0001));
    @(posedge clk); #1;
    chk("resume rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("resume rsp_data",  rsp_data,        R0);
    chk("resume busy",      128'(busy),      128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
